// File: rtl/vert_sched.sv
// Per-frame angle/cosine sequencer: steps the angle once every FRAME_DIV frames, reads the trig ROM, offers angle/cos downstream.
// Optional feature: define VERT_SCHED_DIR_EN to add the `dir` input (1 = angle steps down).
module vert_sched #(
    parameter int FRAME_DIV = 1,
    parameter int ROM_LAT   = 1,
    parameter int ANGLE_MAX = 359
) (
    input  logic               clk_pix,
    input  logic               reset,
    input  logic               frame_start,
    output logic               rom_en,
    output logic [8:0]         rom_addr,
    input  logic signed [11:0] rom_data,
    output logic [8:0]         angle,
    output logic signed [11:0] cos,
    output logic               vtx_valid,
    input  logic               vtx_ready,
    output logic               busy,
    output logic               overrun,
    input  logic               overrun_clr
`ifdef VERT_SCHED_DIR_EN
    ,
    input  logic               dir
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_OFFER} state_t;

    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [1:0] LAT_INIT = 2'(ROM_LAT - 1);
    localparam logic [8:0] AMAX     = 9'(ANGLE_MAX);

    state_t             state, state_nxt;
    logic [7:0]         frame_cnt;
    logic [1:0]         lat_cnt;
    logic               pending;
    logic               overrun_q;
    logic [8:0]         angle_q;
    logic signed [11:0] cos_q;
    logic               start;
    logic               capture;
    logic               extra_start;
    logic [8:0]         angle_up;
    logic [8:0]         angle_step;

    assign angle_up = (angle_q == AMAX) ? '0 : angle_q + 9'd1;

`ifdef VERT_SCHED_DIR_EN
    assign angle_step = dir ? ((angle_q == '0) ? AMAX : angle_q - 9'd1) : angle_up;
`else
    assign angle_step = angle_up;
`endif

    // A frame_start outside IDLE is queued once; a second one while queued is dropped.
    assign extra_start = frame_start && (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start || pending) begin
                    start     = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                if (vtx_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            lat_cnt   <= '0;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
            angle_q   <= '0;
            cos_q     <= '0;
        end else begin
            if (start) begin
                pending <= 1'b0;
                if (frame_cnt == DIV_LAST) begin
                    frame_cnt <= '0;
                    angle_q   <= angle_step;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end else if (extra_start && !pending) begin
                pending <= 1'b1;
            end

            if (extra_start && pending) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            if (state == S_FETCH) begin
                lat_cnt <= LAT_INIT;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt - 2'd1;
            end

            if (capture) begin
                cos_q <= rom_data;
            end
        end
    end

    assign rom_en    = (state == S_FETCH);
    assign rom_addr  = angle_q;
    assign angle     = angle_q;
    assign cos       = cos_q;
    assign vtx_valid = (state == S_OFFER);
    assign busy      = (state != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_vert_sched.sv
// Directed bench for vert_sched: two instances (DIV=1/LAT=1 and DIV=3/LAT=4) fed by latency-accurate ROM models.
module tb_vert_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic               fs_a = 1'b0, rdy_a = 1'b1, clr_a = 1'b0;
    logic               fs_b = 1'b0, rdy_b = 1'b1, clr_b = 1'b0;
    logic               rom_en_a, rom_en_b, vv_a, vv_b, busy_a, busy_b, ovr_a, ovr_b;
    logic [8:0]         addr_a, addr_b, ang_a, ang_b;
    logic signed [11:0] cos_a, cos_b, rd_a, rd_b;
`ifdef VERT_SCHED_DIR_EN
    logic dir = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cur      = 0;

    function automatic logic [11:0] rom_fn(input logic [8:0] a);
        if (a == 9'd1) return 12'd1024;
        return 12'(32'(a) * 5 + 100);
    endfunction

    vert_sched #(.FRAME_DIV(1), .ROM_LAT(1), .ANGLE_MAX(359)) dut_a (
        .clk_pix(clk), .reset(rst), .frame_start(fs_a), .rom_en(rom_en_a), .rom_addr(addr_a),
        .rom_data(rd_a), .angle(ang_a), .cos(cos_a), .vtx_valid(vv_a), .vtx_ready(rdy_a),
        .busy(busy_a), .overrun(ovr_a), .overrun_clr(clr_a)
`ifdef VERT_SCHED_DIR_EN
        , .dir(dir)
`endif
    );

    vert_sched #(.FRAME_DIV(3), .ROM_LAT(4), .ANGLE_MAX(359)) dut_b (
        .clk_pix(clk), .reset(rst), .frame_start(fs_b), .rom_en(rom_en_b), .rom_addr(addr_b),
        .rom_data(rd_b), .angle(ang_b), .cos(cos_b), .vtx_valid(vv_b), .vtx_ready(rdy_b),
        .busy(busy_b), .overrun(ovr_b), .overrun_clr(clr_b)
`ifdef VERT_SCHED_DIR_EN
        , .dir(dir)
`endif
    );

    // ROM models: data is only correct exactly ROM_LAT cycles after rom_en, poison otherwise.
    logic [11:0] pa [4];
    logic [11:0] pb [4];
    logic        va [4];
    logic        vb [4];
    always @(posedge clk) begin
        pa[0] <= rom_en_a ? rom_fn(addr_a) : 12'h0;
        va[0] <= rom_en_a;
        pb[0] <= rom_en_b ? rom_fn(addr_b) : 12'h0;
        vb[0] <= rom_en_b;
        for (int i = 1; i < 4; i++) begin
            pa[i] <= pa[i-1];
            va[i] <= va[i-1];
            pb[i] <= pb[i-1];
            vb[i] <= vb[i-1];
        end
    end
    assign rd_a = va[0] ? pa[0] : 12'h800;
    assign rd_b = vb[3] ? pb[3] : 12'h800;

    logic               rom_en_m, vv_m, busy_m;
    logic [8:0]         addr_m, ang_m;
    logic signed [11:0] cos_m;
    assign rom_en_m = (cur == 0) ? rom_en_a : rom_en_b;
    assign vv_m     = (cur == 0) ? vv_a     : vv_b;
    assign busy_m   = (cur == 0) ? busy_a   : busy_b;
    assign addr_m   = (cur == 0) ? addr_a   : addr_b;
    assign ang_m    = (cur == 0) ? ang_a    : ang_b;
    assign cos_m    = (cur == 0) ? cos_a    : cos_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!vv_m && k < 16) begin
            tick();
            k++;
        end
        check("wait_valid", 32'(vv_m), 1);
    endtask

    task automatic run_frame(input int sel, input logic [8:0] exp_ang, input int exp_lat);
        int k;
        cur = sel;
        if (sel == 0) fs_a = 1'b1; else fs_b = 1'b1;
        tick();
        fs_a = 1'b0;
        fs_b = 1'b0;
        check("fetch_rom_en", 32'(rom_en_m), 1);
        check("fetch_addr", 32'(addr_m), 32'(exp_ang));
        k = 1;
        while (!vv_m && k < 16) begin
            tick();
            k++;
        end
        check("valid_latency", 32'(k), 32'(exp_lat));
        check("offer_angle", 32'(ang_m), 32'(exp_ang));
        check("offer_cos", 32'(cos_m), 32'(rom_fn(exp_ang)));
        tick();
        check("idle_after_accept", 32'(busy_m), 0);
    endtask

    initial begin
        logic seen;
        #1 rst = 1'b1;
        tick();
        check("rst_angle", 32'(ang_a), 0);
        check("rst_cos", 32'(cos_a), 0);
        check("rst_rom_en", 32'(rom_en_a), 0);
        check("rst_rom_addr", 32'(addr_a), 0);
        check("rst_valid", 32'(vv_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_overrun", 32'(ovr_a), 0);
        rst = 1'b0;
        tick();

        // First frame then wrap: angles 1..359, 0
        run_frame(0, 9'd1, 3);
        for (int i = 2; i <= 360; i++) run_frame(0, 9'(i % 360), 3);

        // Backpressure with one queued frame
        cur = 0;
        rdy_a = 1'b0;
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        wait_valid();
        check("bp_angle", 32'(ang_a), 1);
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        check("bp_no_overrun", 32'(ovr_a), 0);
        check("bp_valid_held", 32'(vv_a), 1);
        tick();
        check("bp_angle_stable", 32'(ang_a), 1);
        check("bp_cos_stable", 32'(cos_a), 1024);
        rdy_a = 1'b1;
        tick();
        check("bp_idle_gap", 32'(busy_a), 0);
        check("bp_gap_valid", 32'(vv_a), 0);
        tick();
        check("bp_pending_fetch", 32'(rom_en_a), 1);
        check("bp_pending_addr", 32'(addr_a), 2);
        wait_valid();
        check("bp_pending_angle", 32'(ang_a), 2);
        tick();
        check("bp_done_idle", 32'(busy_a), 0);
        tick();
        check("bp_no_extra", 32'(busy_a), 0);

        // Overrun: two extra starts, then clear racing a third
        rdy_a = 1'b0;
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        wait_valid();
        check("ov_angle", 32'(ang_a), 3);
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        check("ov_first_extra", 32'(ovr_a), 0);
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        check("ov_set", 32'(ovr_a), 1);
        fs_a = 1'b1;
        clr_a = 1'b1;
        tick();
        fs_a = 1'b0;
        clr_a = 1'b0;
        check("ov_set_wins", 32'(ovr_a), 1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("ov_cleared", 32'(ovr_a), 0);
        check("ov_still_offer", 32'(vv_a), 1);
        rdy_a = 1'b1;
        tick();
        check("ov_idle_gap", 32'(busy_a), 0);
        tick();
        check("ov_extra_addr", 32'(addr_a), 4);
        wait_valid();
        check("ov_extra_angle", 32'(ang_a), 4);
        tick();
        check("ov_done", 32'(busy_a), 0);
        tick();
        check("ov_one_extra_only", 32'(busy_a), 0);

        // Divider 3, latency 4
        run_frame(1, 9'd0, 6);
        run_frame(1, 9'd0, 6);
        run_frame(1, 9'd1, 6);
        run_frame(1, 9'd1, 6);
        run_frame(1, 9'd1, 6);
        run_frame(1, 9'd2, 6);
        run_frame(1, 9'd2, 6);
        run_frame(1, 9'd2, 6);
        run_frame(1, 9'd3, 6);

        // Reset in the middle of WAIT
        cur = 1;
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        tick();
        tick();
        check("mid_in_wait", 32'(busy_b), 1);
        rst = 1'b1;
        #1;
        check("mr_angle", 32'(ang_b), 0);
        check("mr_cos", 32'(cos_b), 0);
        check("mr_rom_en", 32'(rom_en_b), 0);
        check("mr_rom_addr", 32'(addr_b), 0);
        check("mr_valid", 32'(vv_b), 0);
        check("mr_busy", 32'(busy_b), 0);
        check("mr_angle_a", 32'(ang_a), 0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | vv_b | busy_b;
        end
        check("mr_no_offer", 32'(seen), 0);

`ifdef VERT_SCHED_DIR_EN
        dir = 1'b1;
        run_frame(0, 9'd359, 3);
        run_frame(0, 9'd358, 3);
        dir = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
